// File: rtl/host_req_arb.sv
// Round-robin arbiter sharing one TL-UL host adapter port between two hosts.
// Tracks the issuing host of each accepted request and routes in-order responses.
module host_req_arb #(
    parameter int DataWidth      = 32,
    parameter int MaxOutstanding = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [1:0]                        host_req_i,
    output logic [1:0]                        host_gnt_o,
    input  logic [1:0][DataWidth-1:0]         host_addr_i,
    input  logic [1:0]                        host_we_i,
    input  logic [1:0][DataWidth-1:0]         host_wdata_i,
    input  logic [1:0][DataWidth/8-1:0]       host_be_i,
    output logic [1:0]                        host_valid_o,
    output logic [DataWidth-1:0]              host_rdata_o,
    output logic                              host_err_o,
    output logic                              dev_req_o,
    output logic                              dev_we_o,
    output logic [DataWidth-1:0]              dev_addr_o,
    output logic [DataWidth-1:0]              dev_wdata_o,
    output logic [DataWidth/8-1:0]            dev_be_o,
    input  logic                              dev_gnt_i,
    input  logic                              dev_valid_i,
    input  logic [DataWidth-1:0]              dev_rdata_i,
    input  logic                              dev_err_i,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                              spurious_rsp_o
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic                      prio_q, prio_d;
    logic                      lock_q, lock_d;
    logic                      lock_idx_q, lock_idx_d;
    logic [MaxOutstanding-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]           wptr_q, wptr_d;
    logic [PtrW-1:0]           rptr_q, rptr_d;
    logic [CntW-1:0]           count_q, count_d;

    logic sel_vld, sel_idx, push, pop, room, head;

    // A response popping this cycle frees a slot, so a full FIFO can still present.
    assign pop  = dev_valid_i & (count_q != '0);
    assign room = (count_q != CntW'(MaxOutstanding)) | pop;
    assign head = fifo_q[rptr_q];

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = prio_q;
        if (lock_q) begin
            sel_vld = 1'b1;
            sel_idx = lock_idx_q;
        end else if (room) begin
            unique case (host_req_i)
                2'b01:   begin sel_vld = 1'b1; sel_idx = 1'b0; end
                2'b10:   begin sel_vld = 1'b1; sel_idx = 1'b1; end
                2'b11:   begin sel_vld = 1'b1; sel_idx = prio_q; end
                default: begin sel_vld = 1'b0; sel_idx = prio_q; end
            endcase
        end
    end

    assign push = sel_vld & dev_gnt_i;

    always_comb begin
        dev_req_o   = sel_vld;
        dev_we_o    = 1'b0;
        dev_addr_o  = '0;
        dev_wdata_o = '0;
        dev_be_o    = '0;
        if (sel_vld) begin
            dev_we_o    = host_we_i[sel_idx];
            dev_addr_o  = host_addr_i[sel_idx];
            dev_wdata_o = host_wdata_i[sel_idx];
            dev_be_o    = host_be_i[sel_idx];
        end
    end

    always_comb begin
        host_gnt_o   = 2'b00;
        host_valid_o = 2'b00;
        if (push) host_gnt_o[sel_idx] = 1'b1;
        if (pop)  host_valid_o[head]  = 1'b1;
    end

    assign host_rdata_o   = dev_rdata_i;
    assign host_err_o     = dev_err_i;
    assign spurious_rsp_o = dev_valid_i & (count_q == '0);
    assign outstanding_o  = count_q;

    always_comb begin
        prio_d     = prio_q;
        lock_d     = sel_vld & ~dev_gnt_i;
        lock_idx_d = sel_vld ? sel_idx : lock_idx_q;
        fifo_d     = fifo_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (push) begin
            fifo_d[wptr_q] = sel_idx;
            prio_d         = ~sel_idx;
            wptr_d = (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + 1'b1;
        end
        if (push & ~pop)      count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q     <= 1'b0;
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            fifo_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            prio_q     <= prio_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            fifo_q     <= fifo_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_host_req_arb.sv
// Randomized bench for host_req_arb: queue-based reference model feeding a
// scoreboard that a negedge monitor drains whenever the DUT grants or responds.
module tb_host_req_arb;

    localparam int DW = 32;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [1:0]         host_req_i;
    logic [1:0]         host_gnt_o;
    logic [1:0][DW-1:0] host_addr_i;
    logic [1:0]         host_we_i;
    logic [1:0][DW-1:0] host_wdata_i;
    logic [1:0][DW/8-1:0] host_be_i;
    logic [1:0]         host_valid_o;
    logic [DW-1:0]      host_rdata_o;
    logic               host_err_o;
    logic               dev_req_o, dev_we_o;
    logic [DW-1:0]      dev_addr_o, dev_wdata_o;
    logic [DW/8-1:0]    dev_be_o;
    logic               dev_gnt_i, dev_valid_i, dev_err_i;
    logic [DW-1:0]      dev_rdata_i;
    logic [CW-1:0]      outstanding_o;
    logic               spurious_rsp_o;

    always #5 clk = ~clk;

    host_req_arb #(.DataWidth(DW), .MaxOutstanding(MO)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_wdata_i(host_wdata_i), .host_be_i(host_be_i),
        .host_valid_o(host_valid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .dev_req_o(dev_req_o), .dev_we_o(dev_we_o),
        .dev_addr_o(dev_addr_o), .dev_wdata_o(dev_wdata_o),
        .dev_be_o(dev_be_o), .dev_gnt_i(dev_gnt_i),
        .dev_valid_i(dev_valid_i), .dev_rdata_i(dev_rdata_i),
        .dev_err_i(dev_err_i),
        .outstanding_o(outstanding_o), .spurious_rsp_o(spurious_rsp_o)
    );

    typedef struct packed {
        logic          h;
        logic [DW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW/8-1:0] be;
    } gnt_t;

    typedef struct packed {
        logic          spur;
        logic          h;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: IDs of accepted transactions in issue order.
    int   ids[$];
    bit   prio;
    bit   lock;
    bit   lock_idx;
    bit   pend[2];
    bit   granted[2];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] onehot(input logic h);
        return h ? 2'b10 : 2'b01;
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (host_gnt_o != 2'b00) begin
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", 64'(host_gnt_o), 64'd0);
                end else begin
                    gnt_t e;
                    e = gnt_q.pop_front();
                    chk("host_gnt", 64'(host_gnt_o), 64'(onehot(e.h)));
                    chk("dev_addr", 64'(dev_addr_o), 64'(e.addr));
                    chk("dev_we", 64'(dev_we_o), 64'(e.we));
                    chk("dev_wdata", 64'(dev_wdata_o), 64'(e.wdata));
                    chk("dev_be", 64'(dev_be_o), 64'(e.be));
                end
            end
            if (host_valid_o != 2'b00 || spurious_rsp_o) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'({host_valid_o, spurious_rsp_o}), 64'd0);
                end else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    chk("host_valid", 64'(host_valid_o),
                        r.spur ? 64'd0 : 64'(onehot(r.h)));
                    chk("spurious", 64'(spurious_rsp_o), 64'(r.spur));
                    chk("rdata", 64'(host_rdata_o), 64'(r.rdata));
                    chk("err", 64'(host_err_o), 64'(r.err));
                end
            end
        end
    end

    task automatic model_reset();
        ids.delete();
        prio = 1'b0;
        lock = 1'b0;
        lock_idx = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        granted[0] = 1'b0;
        granted[1] = 1'b0;
        host_req_i = 2'b00;
        dev_gnt_i = 1'b0;
        dev_valid_i = 1'b0;
        dev_rdata_i = '0;
        dev_err_i = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_outstanding", 64'(outstanding_o), 64'd0);
        chk("rst_dev_req", 64'(dev_req_o), 64'd0);
        chk("rst_dev_addr", 64'(dev_addr_o), 64'd0);
        chk("rst_host_gnt", 64'(host_gnt_o), 64'd0);
        chk("rst_host_valid", 64'(host_valid_o), 64'd0);
        chk("rst_spurious", 64'(spurious_rsp_o), 64'd0);
    endtask

    initial begin
        host_addr_i = '0;
        host_we_i = '0;
        host_wdata_i = '0;
        host_be_i = '0;
        model_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_ni = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int  sz;
            bit  pop, room, exp_req, sel, gnt;
            @(posedge clk);
            #1;
            if (i % 600 == 599) begin
                rst_ni = 1'b0;
                model_reset();
                #1;
                chk_reset_outputs();
                @(posedge clk);
                #1;
                rst_ni = 1'b1;
                continue;
            end

            for (int h = 0; h < 2; h++) begin
                if (granted[h]) pend[h] = 1'b0;
                if (!pend[h] && $urandom_range(0, 99) < 45) begin
                    pend[h] = 1'b1;
                    host_addr_i[h]  = DW'($urandom);
                    host_we_i[h]    = 1'($urandom);
                    host_wdata_i[h] = DW'($urandom);
                    host_be_i[h]    = (DW/8)'($urandom);
                end
                host_req_i[h] = pend[h];
            end
            dev_gnt_i   = ($urandom_range(0, 99) < 60);
            dev_valid_i = ($urandom_range(0, 99) < 40);
            dev_rdata_i = DW'($urandom);
            dev_err_i   = 1'($urandom);

            sz = ids.size();
            pop = dev_valid_i && sz > 0;
            room = (sz != MO) || pop;
            exp_req = 1'b0;
            sel = prio;
            if (lock) begin
                exp_req = 1'b1;
                sel = lock_idx;
            end else if (room && host_req_i != 2'b00) begin
                exp_req = 1'b1;
                if (host_req_i == 2'b11) sel = prio;
                else sel = host_req_i[1];
            end
            gnt = exp_req && dev_gnt_i;

            if (gnt) begin
                gnt_t e;
                e.h = sel;
                e.addr = host_addr_i[sel];
                e.we = host_we_i[sel];
                e.wdata = host_wdata_i[sel];
                e.be = host_be_i[sel];
                gnt_q.push_back(e);
            end
            if (dev_valid_i) begin
                rsp_t r;
                r.spur = (sz == 0);
                r.h = (sz > 0) ? 1'(ids[0]) : 1'b0;
                r.rdata = dev_rdata_i;
                r.err = dev_err_i;
                rsp_q.push_back(r);
            end

            #1;
            chk("dev_req", 64'(dev_req_o), 64'(exp_req));
            chk("outstanding", 64'(outstanding_o), 64'(sz));
            if (!exp_req) chk("idle_addr", 64'(dev_addr_o), 64'd0);

            if (pop) void'(ids.pop_front());
            if (gnt) begin
                ids.push_back(int'(sel));
                prio = ~sel;
            end
            lock = exp_req && !dev_gnt_i;
            lock_idx = sel;
            granted[0] = gnt && sel == 1'b0;
            granted[1] = gnt && sel == 1'b1;
        end

        @(posedge clk);
        #1;
        model_reset();
        @(negedge clk);
        #1;
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
